// File: rtl/dp_sequencer.sv
// -----------------------------------------------------------------------------
// dp_sequencer
//
// Multi-cycle control FSM between the instruction decoder and the 32-bit
// register/shifter/ALU datapath. One decoded instruction is accepted on
// 'start' while idle. The FSM then walks LOAD_A / LOAD_B / EXEC / WB as the
// instruction class requires, and pulses 'done' in the final cycle.
//
// Optional feature (compile-time macro DP_SEQUENCER_COND_EXEC_EN):
//   The condition code 'cond' is evaluated against status_in[31:28] (N,Z,C,V)
//   in the accept cycle. A failing instruction takes a single SKIP cycle that
//   raises done and skipped and issues no enable or write.
//   Without the macro, cond is ignored and skipped is always 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 request strobe, sampled only in IDLE
//   op_class              00 MOV_IMM, 01 ALU_REG, 10 ALU_IMM, 11 CMP
//   alu_op_in, shift_op_in ALU / shift operation of the instruction
//   rd, rn, rm            destination / first source / second source register
//   set_flags             update status in EXEC (forced for CMP)
//   cond, status_in       condition code and datapath status (optional feature)
//   busy, done, skipped   sequencing status
//   wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status   datapath enables
//   w_addr, r_addr        regfile write / read address
//   shift_op, ALU_op      datapath shift / ALU operation
//
// Every output is a flop. It is loaded from a decode of the next state, so it
// reflects the current state in the same cycle the state register does.
// -----------------------------------------------------------------------------
module dp_sequencer #(
    parameter int NREGS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               op_class,
    input  logic [2:0]               alu_op_in,
    input  logic [1:0]               shift_op_in,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] rn,
    input  logic [$clog2(NREGS)-1:0] rm,
    input  logic                     set_flags,
    input  logic [3:0]               cond,
    input  logic [31:0]              status_in,
    output logic                     busy,
    output logic                     done,
    output logic                     skipped,
    output logic                     wb_sel,
    output logic                     w_en,
    output logic                     en_A,
    output logic                     en_B,
    output logic                     sel_A,
    output logic                     sel_B,
    output logic                     en_C,
    output logic                     en_status,
    output logic [$clog2(NREGS)-1:0] w_addr,
    output logic [$clog2(NREGS)-1:0] r_addr,
    output logic [1:0]               shift_op,
    output logic [2:0]               ALU_op
);

    localparam int AW = $clog2(NREGS);

    localparam logic [1:0] CLS_MOV_IMM = 2'b00;
    localparam logic [1:0] CLS_ALU_REG = 2'b01;
    localparam logic [1:0] CLS_ALU_IMM = 2'b10;
    localparam logic [1:0] CLS_CMP     = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        SKIP   = 3'd5
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Latched copies of the accepted instruction.
    logic [1:0]    cls_r;
    logic [2:0]    alu_r;
    logic [1:0]    sh_r;
    logic [AW-1:0] rd_r;
    logic [AW-1:0] rn_r;
    logic [AW-1:0] rm_r;
    logic          sf_r;

    // Instruction fields as seen by the output decode: the live inputs in the
    // accept cycle (so the first-cycle outputs are right), the latches after.
    logic          accept_s;
    logic [1:0]    cls_s;
    logic [2:0]    alu_s;
    logic [1:0]    sh_s;
    logic [AW-1:0] rd_s;
    logic [AW-1:0] rn_s;
    logic [AW-1:0] rm_s;
    logic          sf_s;
    logic          cond_pass_s;

    // Next values of the registered outputs.
    logic          busy_s, done_s, skipped_s, wb_sel_s, w_en_s;
    logic          en_a_s, en_b_s, sel_a_s, sel_b_s, en_c_s, en_status_s;
    logic [AW-1:0] w_addr_s, r_addr_s;
    logic [1:0]    shift_op_s;
    logic [2:0]    alu_op_s;

`ifdef DP_SEQUENCER_COND_EXEC_EN
    // Condition check against the status flags {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] nzcv);
        logic res;
        case (c)
            4'b0000: res = nzcv[2];
            4'b0001: res = ~nzcv[2];
            4'b0010: res = nzcv[1];
            4'b0011: res = ~nzcv[1];
            4'b0100: res = nzcv[3];
            4'b0101: res = ~nzcv[3];
            4'b0110: res = nzcv[0];
            4'b0111: res = ~nzcv[0];
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign cond_pass_s = cond_eval(cond, status_in[31:28]);
    logic unused_status_s;
    assign unused_status_s = ^status_in[27:0];
`else
    assign cond_pass_s = 1'b1;
    logic unused_cond_s;
    assign unused_cond_s = ^{cond, status_in};
`endif

    assign accept_s = (state_r == IDLE) && start;
    assign cls_s    = accept_s ? op_class    : cls_r;
    assign alu_s    = accept_s ? alu_op_in   : alu_r;
    assign sh_s     = accept_s ? shift_op_in : sh_r;
    assign rd_s     = accept_s ? rd          : rd_r;
    assign rn_s     = accept_s ? rn          : rn_r;
    assign rm_s     = accept_s ? rm          : rm_r;
    assign sf_s     = accept_s ? set_flags   : sf_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction latch, loaded only when a request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_r <= 2'b00;
            alu_r <= 3'b000;
            sh_r  <= 2'b00;
            rd_r  <= '0;
            rn_r  <= '0;
            rm_r  <= '0;
            sf_r  <= 1'b0;
        end else if (accept_s) begin
            cls_r <= op_class;
            alu_r <= alu_op_in;
            sh_r  <= shift_op_in;
            rd_r  <= rd;
            rn_r  <= rn;
            rm_r  <= rm;
            sf_r  <= set_flags;
        end else begin
            cls_r <= cls_r;
            alu_r <= alu_r;
            sh_r  <= sh_r;
            rd_r  <= rd_r;
            rn_r  <= rn_r;
            rm_r  <= rm_r;
            sf_r  <= sf_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    state_nxt_s = IDLE;
                end else if (!cond_pass_s) begin
                    state_nxt_s = SKIP;
                end else if (op_class == CLS_MOV_IMM) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = LOAD_A;
                end
            end
            LOAD_A: begin
                if (cls_r == CLS_ALU_IMM) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = LOAD_B;
                end
            end
            LOAD_B:  state_nxt_s = EXEC;
            EXEC: begin
                if (cls_r == CLS_CMP) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WB;
                end
            end
            WB:      state_nxt_s = IDLE;
            SKIP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode of the state being entered.
    always_comb begin
        busy_s      = (state_nxt_s != IDLE);
        done_s      = 1'b0;
        skipped_s   = 1'b0;
        wb_sel_s    = 1'b0;
        w_en_s      = 1'b0;
        en_a_s      = 1'b0;
        en_b_s      = 1'b0;
        sel_a_s     = 1'b0;
        sel_b_s     = 1'b0;
        en_c_s      = 1'b0;
        en_status_s = 1'b0;
        w_addr_s    = '0;
        r_addr_s    = '0;
        shift_op_s  = 2'b00;
        alu_op_s    = 3'b000;
        case (state_nxt_s)
            LOAD_A: begin
                r_addr_s = rn_s;
                en_a_s   = 1'b1;
            end
            LOAD_B: begin
                r_addr_s = rm_s;
                en_b_s   = 1'b1;
            end
            EXEC: begin
                en_c_s      = 1'b1;
                alu_op_s    = alu_s;
                shift_op_s  = sh_s;
                sel_b_s     = (cls_s == CLS_ALU_IMM);
                en_status_s = sf_s | (cls_s == CLS_CMP);
                done_s      = (cls_s == CLS_CMP);
            end
            WB: begin
                w_addr_s = rd_s;
                w_en_s   = 1'b1;
                wb_sel_s = (cls_s == CLS_MOV_IMM);
                done_s   = 1'b1;
                // Keep the EXEC operation steady so C stays valid during
                // writeback; MOV_IMM never passed through EXEC.
                if (cls_s != CLS_MOV_IMM) begin
                    alu_op_s   = alu_s;
                    shift_op_s = sh_s;
                    sel_b_s    = (cls_s == CLS_ALU_IMM);
                end else begin
                    alu_op_s   = 3'b000;
                    shift_op_s = 2'b00;
                    sel_b_s    = 1'b0;
                end
            end
            SKIP: begin
                done_s    = 1'b1;
                skipped_s = 1'b1;
            end
            default: begin
                busy_s = (state_nxt_s != IDLE);
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            skipped   <= 1'b0;
            wb_sel    <= 1'b0;
            w_en      <= 1'b0;
            en_A      <= 1'b0;
            en_B      <= 1'b0;
            sel_A     <= 1'b0;
            sel_B     <= 1'b0;
            en_C      <= 1'b0;
            en_status <= 1'b0;
            w_addr    <= '0;
            r_addr    <= '0;
            shift_op  <= 2'b00;
            ALU_op    <= 3'b000;
        end else begin
            busy      <= busy_s;
            done      <= done_s;
            skipped   <= skipped_s;
            wb_sel    <= wb_sel_s;
            w_en      <= w_en_s;
            en_A      <= en_a_s;
            en_B      <= en_b_s;
            sel_A     <= sel_a_s;
            sel_B     <= sel_b_s;
            en_C      <= en_c_s;
            en_status <= en_status_s;
            w_addr    <= w_addr_s;
            r_addr    <= r_addr_s;
            shift_op  <= shift_op_s;
            ALU_op    <= alu_op_s;
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op_class;
    logic [2:0]  alu_op_in;
    logic [1:0]  shift_op_in;
    logic [3:0]  rd, rn, rm;
    logic        set_flags;
    logic [3:0]  cond;
    logic [31:0] status_in;
    logic        busy, done, skipped, wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status;
    logic [3:0]  w_addr, r_addr;
    logic [1:0]  shift_op;
    logic [2:0]  ALU_op;

    int checks = 0;
    int errors = 0;

    dp_sequencer #(.NREGS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_class(op_class),
        .alu_op_in(alu_op_in), .shift_op_in(shift_op_in),
        .rd(rd), .rn(rn), .rm(rm), .set_flags(set_flags), .cond(cond),
        .status_in(status_in), .busy(busy), .done(done), .skipped(skipped),
        .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B), .sel_A(sel_A),
        .sel_B(sel_B), .en_C(en_C), .en_status(en_status), .w_addr(w_addr),
        .r_addr(r_addr), .shift_op(shift_op), .ALU_op(ALU_op)
    );

    always #5 clk = ~clk;

    // All outputs packed: {busy,done,skipped,wb_sel,w_en,en_A,en_B,sel_A,sel_B,en_C,en_status,w_addr,r_addr,shift_op,ALU_op}
    logic [23:0] ctl;
    assign ctl = {busy, done, skipped, wb_sel, w_en, en_A, en_B, sel_A, sel_B,
                  en_C, en_status, w_addr, r_addr, shift_op, ALU_op};

    function automatic logic [23:0] mk(input logic b, input logic d, input logic sk,
                                       input logic wb, input logic we, input logic ea,
                                       input logic eb, input logic sa, input logic sb,
                                       input logic ec, input logic es, input logic [3:0] wa,
                                       input logic [3:0] ra, input logic [1:0] sh,
                                       input logic [2:0] al);
        return {b, d, sk, wb, we, ea, eb, sa, sb, ec, es, wa, ra, sh, al};
    endfunction

    // Present an instruction with start for one cycle. Returns at the negedge
    // of cycle 1, with the inputs scrambled so that only latched copies matter.
    task automatic issue(input logic [1:0] cls, input logic [2:0] al, input logic [1:0] sh,
                         input logic [3:0] d, input logic [3:0] n, input logic [3:0] m,
                         input logic sf, input logic [3:0] c);
        @(negedge clk);
        op_class = cls; alu_op_in = al; shift_op_in = sh;
        rd = d; rn = n; rm = m; set_flags = sf; cond = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_class = ~cls; alu_op_in = ~al; shift_op_in = ~sh;
        rd = ~d; rn = ~n; rm = ~m; set_flags = ~sf;
    endtask

    task automatic test_reset();
        logic [23:0] exp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp = 24'h000000;
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL reset_state got %h exp %h", ctl, exp); end
        rst = 1'b0;
        // ALU_REG, then reset during LOAD_B for 2 cycles.
        issue(2'b01, 3'b000, 2'b01, 4'd4, 4'd1, 4'd2, 1'b0, 4'b1110);
        @(negedge clk);
        exp = mk(1,0,0,0,0,0,1,0,0,0,0, 4'd0, 4'd2, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL reset_preload_b got %h exp %h", ctl, exp); end
        rst = 1'b1;
        @(negedge clk);
        exp = 24'h000000;
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL reset_abort got %h exp %h", ctl, exp); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== exp) begin errors++; $display("FAIL reset_after%0d got %h exp %h", i, ctl, exp); end
        end
    endtask

    task automatic test_mov_imm();
        logic [23:0] exp;
        issue(2'b00, 3'b101, 2'b10, 4'd3, 4'd9, 4'd10, 1'b1, 4'b1110);
        exp = mk(1,1,0,1,1,0,0,0,0,0,0, 4'd3, 4'd0, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL mov_c1 got %h exp %h", ctl, exp); end
        @(negedge clk);
        exp = 24'h000000;
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL mov_idle got %h exp %h", ctl, exp); end
    endtask

    task automatic test_alu_reg();
        logic [23:0] exp [5];
        exp[0] = mk(1,0,0,0,0,1,0,0,0,0,0, 4'd0, 4'd1, 2'd0, 3'd0);
        exp[1] = mk(1,0,0,0,0,0,1,0,0,0,0, 4'd0, 4'd2, 2'd0, 3'd0);
        exp[2] = mk(1,0,0,0,0,0,0,0,0,1,0, 4'd0, 4'd0, 2'd1, 3'd0);
        exp[3] = mk(1,1,0,0,1,0,0,0,0,0,0, 4'd4, 4'd0, 2'd1, 3'd0);
        exp[4] = 24'h000000;
        issue(2'b01, 3'b000, 2'b01, 4'd4, 4'd1, 4'd2, 1'b0, 4'b1110);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (ctl !== exp[i]) begin errors++; $display("FAIL alu_reg_c%0d got %h exp %h", i + 1, ctl, exp[i]); end
        end
    endtask

    task automatic test_alu_imm();
        logic [23:0] exp [4];
        exp[0] = mk(1,0,0,0,0,1,0,0,0,0,0, 4'd0, 4'd7, 2'd0, 3'd0);
        exp[1] = mk(1,0,0,0,0,0,0,0,1,1,1, 4'd0, 4'd0, 2'd2, 3'd3);
        exp[2] = mk(1,1,0,0,1,0,0,0,1,0,0, 4'd9, 4'd0, 2'd2, 3'd3);
        exp[3] = 24'h000000;
        issue(2'b10, 3'b011, 2'b10, 4'd9, 4'd7, 4'd11, 1'b1, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (ctl !== exp[i]) begin errors++; $display("FAIL alu_imm_c%0d got %h exp %h", i + 1, ctl, exp[i]); end
        end
    endtask

    task automatic test_cmp();
        logic [23:0] exp [4];
        exp[0] = mk(1,0,0,0,0,1,0,0,0,0,0, 4'd0, 4'd5, 2'd0, 3'd0);
        exp[1] = mk(1,0,0,0,0,0,1,0,0,0,0, 4'd0, 4'd6, 2'd0, 3'd0);
        exp[2] = mk(1,1,0,0,0,0,0,0,0,1,1, 4'd0, 4'd0, 2'd3, 3'd2);
        exp[3] = 24'h000000;
        issue(2'b11, 3'b010, 2'b11, 4'd8, 4'd5, 4'd6, 1'b0, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (ctl !== exp[i]) begin errors++; $display("FAIL cmp_c%0d got %h exp %h", i + 1, ctl, exp[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int writes = 0;
        issue(2'b01, 3'b001, 2'b00, 4'd4, 4'd1, 4'd2, 1'b0, 4'b1110);
        // Cycle 1 of the ALU_REG: attempt a MOV_IMM to r7.
        start = 1'b1; op_class = 2'b00; rd = 4'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (w_en === 1'b1) begin
                writes++;
                checks++;
                if (w_addr !== 4'd4) begin errors++; $display("FAIL busy_ignore_waddr got %0d exp 4", w_addr); end
            end
            @(negedge clk);
        end
        checks++;
        if (writes !== 1) begin errors++; $display("FAIL busy_ignore_writes got %0d exp 1", writes); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp;
        @(negedge clk);
        op_class = 2'b00; rd = 4'd2; cond = 4'b1110; start = 1'b1;
        @(negedge clk);
        exp = mk(1,1,0,1,1,0,0,0,0,0,0, 4'd2, 4'd0, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL b2b_first got %h exp %h", ctl, exp); end
        rd = 4'd5;
        @(negedge clk);
        exp = 24'h000000;
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL b2b_done_cycle_ignored got %h exp %h", ctl, exp); end
        @(negedge clk);
        start = 1'b0;
        exp = mk(1,1,0,1,1,0,0,0,0,0,0, 4'd5, 4'd0, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL b2b_second got %h exp %h", ctl, exp); end
        @(negedge clk);
        exp = 24'h000000;
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL b2b_idle got %h exp %h", ctl, exp); end
    endtask

    task automatic test_cond();
        logic [23:0] exp;
        status_in = 32'h0000_0000;
`ifdef DP_SEQUENCER_COND_EXEC_EN
        issue(2'b00, 3'b000, 2'b00, 4'd3, 4'd0, 4'd0, 1'b0, 4'b0000);
        exp = mk(1,1,1,0,0,0,0,0,0,0,0, 4'd0, 4'd0, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL cond_skip got %h exp %h", ctl, exp); end
        @(negedge clk);
        exp = 24'h000000;
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL cond_skip_idle got %h exp %h", ctl, exp); end
        status_in = 32'h4000_0000;
        issue(2'b00, 3'b000, 2'b00, 4'd3, 4'd0, 4'd0, 1'b0, 4'b0000);
        exp = mk(1,1,0,1,1,0,0,0,0,0,0, 4'd3, 4'd0, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL cond_pass got %h exp %h", ctl, exp); end
        @(negedge clk);
`else
        // Condition ignored: even "never" executes.
        issue(2'b00, 3'b000, 2'b00, 4'd3, 4'd0, 4'd0, 1'b0, 4'b1111);
        exp = mk(1,1,0,1,1,0,0,0,0,0,0, 4'd3, 4'd0, 2'd0, 3'd0);
        checks++;
        if (ctl !== exp) begin errors++; $display("FAIL cond_ignored got %h exp %h", ctl, exp); end
        @(negedge clk);
`endif
        status_in = 32'h0000_0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_class = 2'b00; alu_op_in = 3'b000;
        shift_op_in = 2'b00; rd = 4'd0; rn = 4'd0; rm = 4'd0;
        set_flags = 1'b0; cond = 4'b1110; status_in = 32'h0000_0000;
        test_reset();
        test_mov_imm();
        test_alu_reg();
        test_alu_imm();
        test_cmp();
        test_busy_ignore();
        test_back_to_back();
        test_cond();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
